// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM states and command opcodes.
// Optional feature macro: COUNTER_SEQ_AUTORELOAD_EN.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_START,
        OP_STOP,
        OP_LOAD
    } cmd_op_e;

endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// Clock-enable prescaler: one-cycle tick every DIV cycles while enabled.
// Held at zero whenever disabled or cleared.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || !en || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven up/down counter sequencer with a clock-enable prescaler.
// Optional auto-reload on limit: define COUNTER_SEQ_AUTORELOAD_EN.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIV   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             updn,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] value,
    output logic             running,
    output logic             tick,
    output logic             done
);

    state_e           state;
    state_e           state_next;
    cmd_op_e          op;
    logic             accept;
    logic             do_start;
    logic             do_stop;
    logic             do_load;
    logic             in_run;
    logic             hit;
    logic             updn_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] step_val;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
    logic [WIDTH-1:0] reload;
    logic             done_r;
`endif

    assign op       = cmd_op_e'(cmd_op);
    assign accept   = cmd_valid && cmd_ready;
    assign do_start = accept && (op == OP_START);
    assign do_stop  = accept && (op == OP_STOP);
    assign do_load  = accept && (op == OP_LOAD);
    assign in_run   = (state == RUN);
    assign step_val = updn_q ? value + 1'b1 : value - 1'b1;

    // Any accepted command overrides the limit compare for this tick
    assign hit = tick && (step_val == limit_q)
               && !(do_start || do_stop || do_load);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (in_run),
        .clr  (do_start),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (do_start) state_next = RUN;
            end
            RUN: begin
                if (do_stop) begin
                    state_next = IDLE;
                end
`ifndef COUNTER_SEQ_AUTORELOAD_EN
                else if (hit) begin
                    state_next = DONE;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        running   = (state == RUN);
        cmd_ready = (state != DONE);
        done      = (state == DONE);
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        done      = done | done_r;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value   <= '0;
            limit_q <= '0;
            updn_q  <= 1'b0;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
            reload  <= '0;
            done_r  <= 1'b0;
`endif
        end else begin
            if (do_start) begin
                limit_q <= limit;
                updn_q  <= updn;
            end
            if (do_load) begin
                value  <= cmd_data;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
                reload <= cmd_data;
`endif
            end else if (tick && !do_start) begin
`ifdef COUNTER_SEQ_AUTORELOAD_EN
                value <= hit ? reload : step_val;
`else
                value <= step_val;
`endif
            end
`ifdef COUNTER_SEQ_AUTORELOAD_EN
            done_r <= hit;
`endif
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed scoreboard bench for counter_sequencer (one-shot or auto-reload build).
module tb_counter_sequencer;
    import counter_seq_pkg::*;

`ifdef COUNTER_SEQ_AUTORELOAD_EN
    localparam int DIVP = 1;
`else
    localparam int DIVP = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        updn;
    logic [31:0] limit;
    logic [31:0] value;
    logic        running;
    logic        tick;
    logic        done;

    int          total = 0;
    int          bad = 0;
    int          n = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    counter_sequencer #(
        .WIDTH (32),
        .DIV   (DIVP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .updn      (updn),
        .limit     (limit),
        .value     (value),
        .running   (running),
        .tick      (tick),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one command at a negedge; returns at the next negedge
    task automatic send(input logic [1:0] o, input logic [31:0] d,
                        input logic u, input logic [31:0] lim);
        cmd_valid = 1'b1;
        cmd_op    = o;
        cmd_data  = d;
        updn      = u;
        limit     = lim;
        @(posedge clk);
        @(negedge clk);
        n++;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic wait_tick(input string tag);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            n++;
            b++;
        end while (!tick && b < 3 * DIVP + 5);
        chk({tag, "_tick_seen"}, {31'd0, tick}, 32'd1);
    endtask

    task automatic step_check(input string tag, input int exp_n);
        logic [31:0] e;
        wait_tick(tag);
        chk({tag, "_tick_cycle"}, n, exp_n);
        @(negedge clk);
        n++;
        e = exp_q.pop_front();
        chk({tag, "_value"}, value, e);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        updn      = 1'b0;
        limit     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_value", value, 32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (20) @(negedge clk);
        chk("idle_value", value, 32'd0);
        chk("idle_running", {31'd0, running}, 32'd0);

`ifdef COUNTER_SEQ_AUTORELOAD_EN
        send(OP_LOAD, 32'd2, 1'b0, 32'd0);
        chk("ar_load", value, 32'd2);
        n = 0;
        send(OP_START, 32'd0, 1'b1, 32'd4);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd2);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk($sformatf("ar_value%0d", i), value, e);
            chk($sformatf("ar_done%0d", i), {31'd0, done},
                (i == 2 || i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("ar_running%0d", i), {31'd0, running}, 32'd1);
            chk($sformatf("ar_ready%0d", i), {31'd0, cmd_ready}, 32'd1);
            @(negedge clk);
        end
        send(OP_STOP, 32'd0, 1'b0, 32'd0);
        chk("ar_stop", {31'd0, running}, 32'd0);
`else
        // Count up 5 -> 8, one-shot done
        send(OP_LOAD, 32'd5, 1'b0, 32'd0);
        chk("load5", value, 32'd5);
        n = 0;
        send(OP_START, 32'd0, 1'b1, 32'd8);
        chk("up_running", {31'd0, running}, 32'd1);
        exp_q.push_back(32'd6);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd8);
        step_check("up1", 10);
        step_check("up2", 20);
        step_check("up3", 30);
        chk("up_done_cycle", n, 32'd31);
        chk("up_done", {31'd0, done}, 32'd1);
        chk("up_done_running", {31'd0, running}, 32'd0);
        chk("up_done_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("up_after_done", {31'd0, done}, 32'd0);
        chk("up_after_running", {31'd0, running}, 32'd0);
        chk("up_after_ready", {31'd0, cmd_ready}, 32'd1);
        chk("up_after_value", value, 32'd8);

        // Count down across the wrap
        send(OP_LOAD, 32'd0, 1'b0, 32'd0);
        n = 0;
        send(OP_START, 32'd0, 1'b0, 32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFE);
        step_check("dn1", 10);
        chk("dn1_nodone", {31'd0, done}, 32'd0);
        step_check("dn2", 20);
        chk("dn2_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // STOP coincident with the third tick
        send(OP_LOAD, 32'd0, 1'b0, 32'd0);
        n = 0;
        send(OP_START, 32'd0, 1'b1, 32'd100);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd2);
        step_check("st1", 10);
        step_check("st2", 20);
        wait_tick("st3");
        chk("st3_cycle", n, 32'd30);
        send(OP_STOP, 32'd0, 1'b0, 32'd0);
        chk("stop_value", value, 32'd3);
        chk("stop_running", {31'd0, running}, 32'd0);
        chk("stop_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("stop_hold", value, 32'd3);
        n = 0;
        send(OP_START, 32'd0, 1'b1, 32'd100);
        exp_q.push_back(32'd4);
        step_check("resume", 10);

        // LOAD coincident with a tick
        wait_tick("ld_tick");
        chk("ld_tick_cycle", n, 32'd20);
        send(OP_LOAD, 32'd50, 1'b0, 32'd0);
        chk("ld_value", value, 32'd50);
        chk("ld_running", {31'd0, running}, 32'd1);
        exp_q.push_back(32'd51);
        step_check("ld_next", 30);
        send(OP_STOP, 32'd0, 1'b0, 32'd0);
`endif

        // Reset mid-operation drops an in-flight LOAD
        send(OP_START, 32'd0, 1'b1, 32'd1000);
        repeat (5) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 32'd77;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        chk("midrst_value", value, 32'd0);
        chk("midrst_running", {31'd0, running}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
